// File: rtl/split_bus_pkg.sv
// Shared encodings for the split-transaction bus arbiter: FSM states, slave
// select codes and small decode helpers.
package split_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEL     = 3'd1,
        ST_CHECK   = 3'd2,
        ST_CONNECT = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [1:0] S1_SEL  = 2'd0;
    localparam logic [1:0] S2_SEL  = 2'd1;
    localparam logic [1:0] S3_SEL  = 2'd2;
    localparam logic [1:0] BAD_SEL = 2'd3;

    // Ready flag of the addressed slave; the invalid select never reads ready.
    function automatic logic sel_ready(input logic [1:0] sel, input logic [2:0] rdy);
        case (sel)
            S1_SEL:  return rdy[0];
            S2_SEL:  return rdy[1];
            S3_SEL:  return rdy[2];
            default: return 1'b0;
        endcase
    endfunction

    // Master index (0 = m1, 1 = m2) to one-hot {m2, m1}.
    function automatic logic [1:0] master_bit(input logic m);
        return m ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Two-input round-robin pick, purely combinational: a lone requester wins,
// a tie goes to the master that was not granted last.
module rr_picker (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       pick
);

    always_comb begin
        valid = |req;
        pick  = 1'b0;
        if (req == 2'b11) begin
            pick = ~last;
        end else begin
            pick = req[1];
        end
    end

endmodule

// File: rtl/split_bus_arbiter.sv
// Two-master / three-slave serial bus arbiter with split transactions and a
// CONNECT watchdog; every output is a flop, one cycle behind the deciding edge.
module split_bus_arbiter
    import split_bus_pkg::*;
#(
    parameter int SEL_BITS = 2,
    parameter int TIMEOUT  = 1023,
    parameter int CW       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1_request,
    input  logic       m1_address,
    input  logic       m1_address_valid,
    input  logic       m2_request,
    input  logic       m2_address,
    input  logic       m2_address_valid,
    input  logic       s1_ready,
    input  logic       s2_ready,
    input  logic       s3_ready,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       m1_available,
    output logic       m2_available,
    output logic       m1_split,
    output logic       m2_split,
    output logic       m1_error,
    output logic       m2_error,
    output logic [1:0] slave_sel,
    output logic       bus_ready_s1,
    output logic       bus_ready_s2,
    output logic       bus_ready_s3,
    output logic [2:0] state
);

    localparam int BCW = $clog2(SEL_BITS + 1);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    wd_q, wd_d;
    logic [1:0]       sel_q, sel_d;
    logic             split_pend_q, split_pend_d;
    logic             split_m_q, split_m_d;
    logic [1:0]       split_s_q, split_s_d;

    logic [1:0]       grant_q, grant_d;
    logic [1:0]       avail_q, avail_d;
    logic [1:0]       split_q, split_d;
    logic [1:0]       err_q, err_d;
    logic [2:0]       bready_q, bready_d;

    logic [1:0]       req, av, ad, mask;
    logic [2:0]       rdy;
    logic             own_req, own_av, own_ad;
    logic             pick_vld, pick;
    logic             on_bus, connected;

    assign req     = {m2_request, m1_request};
    assign av      = {m2_address_valid, m1_address_valid};
    assign ad      = {m2_address, m1_address};
    assign rdy     = {s3_ready, s2_ready, s1_ready};
    assign own_req = req[owner_q];
    assign own_av  = av[owner_q];
    assign own_ad  = ad[owner_q];

    // A parked (split) master does not compete until its slave frees up.
    assign mask = split_pend_q ? master_bit(split_m_q) : 2'b00;

    rr_picker u_rr (
        .req   (req & ~mask),
        .last  (last_q),
        .valid (pick_vld),
        .pick  (pick)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        bit_cnt_d    = bit_cnt_q;
        wd_d         = wd_q;
        sel_d        = sel_q;
        split_pend_d = split_pend_q;
        split_m_d    = split_m_q;
        split_s_d    = split_s_q;
        err_d        = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (split_pend_q && !req[split_m_q]) begin
                    split_pend_d = 1'b0;
                end
                // Resuming a split transfer beats fresh arbitration and skips SEL.
                if (split_pend_q && req[split_m_q] && sel_ready(split_s_q, rdy)) begin
                    split_pend_d = 1'b0;
                    owner_d      = split_m_q;
                    sel_d        = split_s_q;
                    wd_d         = '0;
                    state_d      = ST_CONNECT;
                end else if (pick_vld) begin
                    owner_d   = pick;
                    bit_cnt_d = '0;
                    state_d   = ST_SEL;
                end
            end

            ST_SEL: begin
                if (!own_req) begin
                    state_d = ST_IDLE;
                end else if (own_av) begin
                    sel_d     = {sel_q[0], own_ad};
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == BCW'(SEL_BITS - 1)) begin
                        state_d = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (sel_q == BAD_SEL) begin
                    err_d   = master_bit(owner_q);
                    state_d = ST_RELEASE;
                end else if (sel_ready(sel_q, rdy)) begin
                    wd_d    = '0;
                    state_d = ST_CONNECT;
                end else if (!split_pend_q) begin
                    split_pend_d = 1'b1;
                    split_m_d    = owner_q;
                    split_s_d    = sel_q;
                    state_d      = ST_RELEASE;
                end else if (!own_req) begin
                    state_d = ST_RELEASE;
                end
            end

            ST_CONNECT: begin
                if (!own_req) begin
                    state_d = ST_RELEASE;
                end else if (wd_q == CW'(TIMEOUT)) begin
                    err_d   = master_bit(owner_q);
                    state_d = ST_RELEASE;
                end else begin
                    wd_d = wd_q + CW'(1);
                end
            end

            ST_RELEASE: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output flops are loaded from the decoded next state.
    always_comb begin
        on_bus    = (state_d == ST_SEL) || (state_d == ST_CHECK) || (state_d == ST_CONNECT);
        connected = (state_d == ST_CONNECT);
        grant_d   = on_bus    ? master_bit(owner_d) : 2'b00;
        avail_d   = connected ? master_bit(owner_d) : 2'b00;
        bready_d  = connected ? (3'b001 << sel_d) : 3'b000;
        split_d   = split_pend_d ? master_bit(split_m_d) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            bit_cnt_q    <= '0;
            wd_q         <= '0;
            sel_q        <= 2'b00;
            split_pend_q <= 1'b0;
            split_m_q    <= 1'b0;
            split_s_q    <= 2'b00;
            grant_q      <= 2'b00;
            avail_q      <= 2'b00;
            split_q      <= 2'b00;
            err_q        <= 2'b00;
            bready_q     <= 3'b000;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            bit_cnt_q    <= bit_cnt_d;
            wd_q         <= wd_d;
            sel_q        <= sel_d;
            split_pend_q <= split_pend_d;
            split_m_q    <= split_m_d;
            split_s_q    <= split_s_d;
            grant_q      <= grant_d;
            avail_q      <= avail_d;
            split_q      <= split_d;
            err_q        <= err_d;
            bready_q     <= bready_d;
        end
    end

    assign m1_grant     = grant_q[0];
    assign m2_grant     = grant_q[1];
    assign m1_available = avail_q[0];
    assign m2_available = avail_q[1];
    assign m1_split     = split_q[0];
    assign m2_split     = split_q[1];
    assign m1_error     = err_q[0];
    assign m2_error     = err_q[1];
    assign slave_sel    = sel_q;
    assign bus_ready_s1 = bready_q[0];
    assign bus_ready_s2 = bready_q[1];
    assign bus_ready_s3 = bready_q[2];
    assign state        = state_q;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Directed-plus-random bench for split_bus_arbiter against a transaction-level
// model of arbitration order, select decoding, split parking and watchdog.
module tb_split_bus_arbiter;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:1] req, adr, adv;
    logic [3:1] rdy;

    logic       m1_grant, m2_grant, m1_available, m2_available;
    logic       m1_split, m2_split, m1_error, m2_error;
    logic       bus_ready_s1, bus_ready_s2, bus_ready_s3;
    logic [1:0] slave_sel;
    logic [2:0] state;

    always #5 clk = ~clk;

    split_bus_arbiter #(.SEL_BITS(2), .TIMEOUT(TO), .CW(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .m1_request       (req[1]),
        .m1_address       (adr[1]),
        .m1_address_valid (adv[1]),
        .m2_request       (req[2]),
        .m2_address       (adr[2]),
        .m2_address_valid (adv[2]),
        .s1_ready         (rdy[1]),
        .s2_ready         (rdy[2]),
        .s3_ready         (rdy[3]),
        .m1_grant         (m1_grant),
        .m2_grant         (m2_grant),
        .m1_available     (m1_available),
        .m2_available     (m2_available),
        .m1_split         (m1_split),
        .m2_split         (m2_split),
        .m1_error         (m1_error),
        .m2_error         (m2_error),
        .slave_sel        (slave_sel),
        .bus_ready_s1     (bus_ready_s1),
        .bus_ready_s2     (bus_ready_s2),
        .bus_ready_s3     (bus_ready_s3),
        .state            (state)
    );

    logic [2:1] g_v, a_v, s_v, e_v;
    logic [3:1] b_v;
    assign g_v = {m2_grant, m1_grant};
    assign a_v = {m2_available, m1_available};
    assign s_v = {m2_split, m1_split};
    assign e_v = {m2_error, m1_error};
    assign b_v = {bus_ready_s3, bus_ready_s2, bus_ready_s1};

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who was served last, and the parked split transaction.
    int last_m;
    bit sp_pend;
    int sp_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:1] mbit(input int m);
        logic [2:1] r;
        r = '0;
        if (m == 1) r[1] = 1'b1;
        if (m == 2) r[2] = 1'b1;
        return r;
    endfunction

    function automatic logic [3:1] sbit(input int s);
        logic [3:1] r;
        r = '0;
        if (s >= 1 && s <= 3) r[s] = 1'b1;
        return r;
    endfunction

    function automatic int rr_winner(input logic [2:1] r);
        if (r == 2'b11) return (last_m == 1) ? 2 : 1;
        return r[1] ? 1 : 2;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // gm/am/em: master index or 0; bs: slave index or 0.
    task automatic expect_outs(input string tag, input int st, input int gm,
                               input int am, input int em, input int bs);
        chk({tag, "/state"}, state, st);
        chk({tag, "/grant"}, g_v, mbit(gm));
        chk({tag, "/avail"}, a_v, mbit(am));
        chk({tag, "/error"}, e_v, mbit(em));
        chk({tag, "/bus_ready"}, b_v, sbit(bs));
        chk({tag, "/split"}, s_v, sp_pend ? mbit(sp_m) : 2'b00);
    endtask

    // Entered at a negedge in IDLE with m's request up and m the expected winner.
    // hold = CONNECT cycles wanted (0: return while still connected).
    task automatic transact(input int m, input int sel, input int hold, input bit keep);
        logic [1:0] sb;
        int s, gap, n;
        sb = 2'(sel);
        s  = sel + 1;
        tick();
        expect_outs("grant", 1, m, 0, 0, 0);
        for (int i = 1; i >= 0; i--) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                adv[m]     = 1'b0;
                adr[m]     = 1'($urandom);
                adv[3 - m] = 1'($urandom);
                adr[3 - m] = 1'($urandom);
                tick();
                chk("sel_wait/state", state, 1);
            end
            adv[m] = 1'b1;
            adr[m] = sb[i];
            tick();
        end
        adv = '0;
        expect_outs("check", 2, m, 0, 0, 0);
        chk("check/slave_sel", slave_sel, sb);
        if (sel == 3) begin
            tick();
            expect_outs("bad_sel", 4, 0, 0, m, 0);
            req[m] = keep;
            last_m = m;
            tick();
            expect_outs("bad_idle", 0, 0, 0, 0, 0);
        end else if (rdy[s]) begin
            if (hold == 0) begin
                tick();
                expect_outs("connect", 3, m, m, 0, s);
                return;
            end
            n = (hold > TO + 1) ? TO + 1 : hold;
            for (int k = 0; k < n; k++) begin
                tick();
                expect_outs("connect", 3, m, m, 0, s);
            end
            if (hold > TO + 1) begin
                tick();
                expect_outs("timeout", 4, 0, 0, m, 0);
            end else begin
                req[m] = 1'b0;
                tick();
                expect_outs("release", 4, 0, 0, 0, 0);
            end
            req[m] = keep;
            last_m = m;
            tick();
            expect_outs("idle", 0, 0, 0, 0, 0);
        end else if (!sp_pend) begin
            tick();
            sp_pend = 1'b1;
            sp_m    = m;
            expect_outs("split", 4, 0, 0, 0, 0);
            last_m = m;
            tick();
            expect_outs("split_idle", 0, 0, 0, 0, 0);
        end else begin
            repeat (3) begin
                tick();
                expect_outs("stall", 2, m, 0, 0, 0);
            end
            req[m] = 1'b0;
            tick();
            expect_outs("stall_rel", 4, 0, 0, 0, 0);
            req[m] = keep;
            last_m = m;
            tick();
            expect_outs("stall_idle", 0, 0, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0; adr = '0; adv = '0; rdy = '0;
        repeat (2) tick();
        reset   = 1'b0;
        last_m  = 2;
        sp_pend = 1'b0;
        expect_outs("reset", 0, 0, 0, 0, 0);
        chk("reset/slave_sel", slave_sel, 0);
    endtask

    initial begin
        int w, sel;
        reset = 1'b1;
        req = '0; adr = '0; adv = '0; rdy = '0;
        last_m = 2; sp_pend = 1'b0; sp_m = 1;

        // Single master to s2.
        do_reset();
        rdy = 3'b010;
        req[1] = 1'b1;
        transact(1, 1, 3, 1'b0);

        // Round-robin with both requesting continuously: m1, m2, m1.
        do_reset();
        rdy = 3'b111;
        req = 2'b11;
        for (int t = 0; t < 3; t++) begin
            w = rr_winner(req);
            chk("rr/order", w, (t % 2 == 0) ? 1 : 2);
            transact(w, $urandom_range(0, 2), $urandom_range(1, 3), 1'b1);
        end
        req = '0;
        tick();

        // Invalid select from m2.
        req[2] = 1'b1;
        transact(2, 3, 1, 1'b0);

        // Split: m1 parks on busy s3, m2 is served, m2 stalls on s3, then m1 resumes.
        rdy = 3'b011;
        req[1] = 1'b1;
        transact(1, 2, 1, 1'b0);
        req[2] = 1'b1;
        transact(2, $urandom_range(0, 1), 2, 1'b0);
        repeat (3) begin
            tick();
            expect_outs("parked", 0, 0, 0, 0, 0);
        end
        req[2] = 1'b1;
        transact(2, 2, 1, 1'b0);
        rdy[3] = 1'b1;
        tick();
        sp_pend = 1'b0;
        expect_outs("resume", 3, 1, 1, 0, 3);
        chk("resume/slave_sel", slave_sel, 2);
        tick();
        expect_outs("resume2", 3, 1, 1, 0, 3);
        req[1] = 1'b0;
        tick();
        expect_outs("resume_rel", 4, 0, 0, 0, 0);
        last_m = 1;
        tick();

        // Split cancelled by the parked master dropping its request.
        rdy = 3'b011;
        req[1] = 1'b1;
        transact(1, 2, 1, 1'b0);
        req[1] = 1'b0;
        tick();
        sp_pend = 1'b0;
        expect_outs("split_cancel", 0, 0, 0, 0, 0);

        // Request dropped during SEL: back to IDLE silently.
        req[2] = 1'b1;
        tick();
        expect_outs("sel_abort_grant", 1, 2, 0, 0, 0);
        req[2] = 1'b0;
        tick();
        expect_outs("sel_abort", 0, 0, 0, 0, 0);
        tick();
        expect_outs("sel_abort2", 0, 0, 0, 0, 0);

        // Watchdog: m1 never lets go.
        rdy = 3'b111;
        req[1] = 1'b1;
        transact(1, $urandom_range(0, 2), TO + 10, 1'b0);

        // Random traffic, target slave always ready or invalid select.
        for (int t = 0; t < 20; t++) begin
            req = 2'($urandom_range(1, 3));
            w   = rr_winner(req);
            sel = $urandom_range(0, 3);
            rdy = 3'($urandom);
            if (sel != 3) rdy[sel + 1] = 1'b1;
            transact(w, sel, $urandom_range(1, 4), 1'b0);
        end
        req = '0;
        tick();

        // Reset while m2 is connected and m1 is parked.
        rdy = 3'b011;
        req[1] = 1'b1;
        transact(1, 2, 1, 1'b0);
        req[2] = 1'b1;
        transact(2, 0, 0, 1'b0);
        reset = 1'b1;
        tick();
        sp_pend = 1'b0;
        last_m  = 2;
        expect_outs("rst_connect", 0, 0, 0, 0, 0);
        chk("rst_connect/slave_sel", slave_sel, 0);
        reset = 1'b0;
        rdy = 3'b111;
        chk("rst_rr/winner", rr_winner(req), 1);
        transact(1, $urandom_range(0, 2), 1, 1'b0);
        req = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
